pipe_issue_ctrl: RTL and testbench

- Issue controller in front of the 3-stage ALU pipeline (S1 decode/regfile read, S2 execute, S3 writeback).
- Buffers incoming instructions in a small FIFO and presents one instruction per cycle on the pipeline's instruction/write-enable inputs.
- The pipeline has no forwarding, so the controller inserts bubbles whenever the FIFO head reads a register still being written by an in-flight instruction.

---
 rtl/pipe_issue_if.sv | 33 +++
 rtl/pipe_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_issue_if.sv
// ---------------------------------------------------------------------------
// pipe_issue_if
//   Handshake and instruction bus between a producer, the issue controller,
//   and the 3-stage ALU pipeline.
//
//   in_instr  : instruction from the producer
//   in_valid  : in_instr is valid
//   in_ready  : controller FIFO can accept an instruction
//   hold      : freeze issue; bubbles are issued while high
//   out_instr : instruction to the pipeline InstrIn (0 on a bubble)
//   out_we    : pipeline WriteEnable for out_instr (0 = bubble)
//
//   master : producer / pipeline side (testbench)
//   slave  : issue controller side
// ---------------------------------------------------------------------------
interface pipe_issue_if;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic [31:0] out_instr;
  logic        out_we;

  modport master (
    output in_instr, in_valid, hold,
    input  in_ready, out_instr, out_we
  );

  modport slave (
    input  in_instr, in_valid, hold,
    output in_ready, out_instr, out_we
  );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl
//   Issue controller for a 3-stage ALU pipeline without forwarding.
//   Instructions are buffered in a DEPTH-entry FIFO and issued in order, one
//   per cycle. A scoreboard of recently issued write-selects holds back the
//   FIFO head (issuing bubbles) until its source registers have been written.
//
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus        : pipe_issue_if.slave (in_instr/in_valid/in_ready/hold/
//                out_instr/out_we)
//   state      : 0=IDLE, 1=ISSUE, 2=STALL (registered)
//   fifo_count : FIFO occupancy
//   stall_cnt  : cycles lost to hazards, saturating
//   issue_cnt  : instructions issued, wrapping
// ---------------------------------------------------------------------------
module pipe_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int HAZ_DEPTH = 3,
  parameter int WS_LSB    = 23,
  parameter int RS1_LSB   = 18,
  parameter int RS2_LSB   = 13,
  parameter int SRC_BIT   = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_issue_if.slave              bus,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              issue_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // FIFO storage and pointers
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Scoreboard: entry 0 is the most recent issue slot
  logic [HAZ_DEPTH-1:0] sb_valid;
  logic [4:0]           sb_ws [HAZ_DEPTH];

  // Registered pipeline-facing outputs
  logic [31:0] out_instr_q;
  logic        out_we_q;

  state_t state_q;
  state_t state_d;

  logic [31:0] head;
  logic [4:0]  head_ws;
  logic [4:0]  head_rs1;
  logic [4:0]  head_rs2;
  logic        head_imm;
  logic        not_empty;
  logic        push;
  logic        issue;
  logic        hazard;
  logic        stall_event;
  logic        sb_busy_next;

  assign head      = mem[rd_ptr];
  assign head_ws   = head[WS_LSB  +: 5];
  assign head_rs1  = head[RS1_LSB +: 5];
  assign head_rs2  = head[RS2_LSB +: 5];
  assign head_imm  = head[SRC_BIT];
  assign not_empty = (count != '0);

  // A full FIFO refuses a push even when the head pops this cycle.
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;

  // The oldest scoreboard slot writes the regfile during the cycle its
  // successor is read, so it no longer blocks the head; it is kept only so
  // the state reports STALL until that write has completed.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH - 1; i++) begin
      if (sb_valid[i] && (sb_ws[i] == head_rs1))
        hazard = 1'b1;
      if (!head_imm && sb_valid[i] && (sb_ws[i] == head_rs2))
        hazard = 1'b1;
    end
  end

  assign issue       = not_empty && !bus.hold && !hazard;
  assign stall_event = not_empty && !bus.hold && hazard;

  // Scoreboard occupancy as it will be after this edge's shift, ignoring the
  // incoming slot (which only matters when issuing, and then state is ISSUE).
  always_comb begin
    sb_busy_next = 1'b0;
    for (int i = 0; i < HAZ_DEPTH - 1; i++)
      sb_busy_next = sb_busy_next | sb_valid[i];
  end

  // NOTE: storage carries no reset; only pointers and count define which
  // entries are live, so clearing the array would be wasted logic.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.in_instr;
  end

  // NOTE: every sequential assignment uses <= so all registers update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sb_valid    <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++)
        sb_ws[i] <= '0;
      out_instr_q <= '0;
      out_we_q    <= 1'b0;
      stall_cnt   <= '0;
      issue_cnt   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (issue)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_ws[i]    <= sb_ws[i-1];
      end
      sb_valid[0] <= issue;
      sb_ws[0]    <= issue ? head_ws : 5'd0;

      if (issue) begin
        out_instr_q <= head;
        out_we_q    <= 1'b1;
        issue_cnt   <= issue_cnt + 16'd1;
      end else begin
        out_instr_q <= '0;
        out_we_q    <= 1'b0;
      end

      if (stall_event && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next state is a pure function of this cycle's conditions; no memory.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_d = ST_IDLE;
    if (issue)
      state_d = ST_ISSUE;
    else if (not_empty || sb_busy_next)
      state_d = ST_STALL;
  end

  assign bus.out_instr = out_instr_q;
  assign bus.out_we    = out_we_q;
  assign state         = state_q;
  assign fifo_count    = count;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_issue_ctrl
//   Directed bench for pipe_issue_ctrl at default parameters. Inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [2:0]  fifo_count;
  logic [15:0] stall_cnt;
  logic [15:0] issue_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_issue_if bus ();

  pipe_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .state      (state),
    .fifo_count (fifo_count),
    .stall_cnt  (stall_cnt),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr,
                            input logic we);
    check({tag, "_we"}, 32'(bus.out_we), 32'(we));
    check({tag, "_instr"}, bus.out_instr, instr);
  endtask

  // Field layout: [28]=src, [27:23]=ws, [22:18]=rs1, [17:13]=rs2, [12:0]=tag
  function automatic logic [31:0] mk(input logic [4:0] ws, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic src,
                                     input logic [12:0] tag);
    logic [31:0] r;
    r = '0;
    r[28]    = src;
    r[27:23] = ws;
    r[22:18] = rs1;
    r[17:13] = rs2;
    r[12:0]  = tag;
    return r;
  endfunction

  task automatic drain_to_idle(input string tag);
    step(); step(); step();
    check({tag, "_idle"}, 32'(state), 32'(IDLE));
  endtask

  logic [31:0] a, b, c, d, e, f;
  logic [31:0] t1 [3];
  logic [31:0] h  [5];

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.hold     = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_we",     32'(bus.out_we), 32'd0);
    check("rst_instr",  bus.out_instr, 32'd0);
    check("rst_state",  32'(state), 32'(IDLE));
    check("rst_count",  32'(fifo_count), 32'd0);
    check("rst_stall",  32'(stall_cnt), 32'd0);
    check("rst_issue",  32'(issue_cnt), 32'd0);
    check("rst_ready",  32'(bus.in_ready), 32'd1);

    // 1: three independent instructions stream through back-to-back
    t1[0] = mk(5'd1, 5'd4, 5'd5, 1'b0, 13'h101);
    t1[1] = mk(5'd2, 5'd4, 5'd5, 1'b0, 13'h102);
    t1[2] = mk(5'd3, 5'd4, 5'd5, 1'b0, 13'h103);
    bus.in_valid = 1'b1;
    bus.in_instr = t1[0];
    step();
    check("t1_lat_we", 32'(bus.out_we), 32'd0);
    bus.in_instr = t1[1];
    step();
    expect_out("t1_i0", t1[0], 1'b1);
    check("t1_state_issue", 32'(state), 32'(ISSUE));
    bus.in_instr = t1[2];
    step();
    expect_out("t1_i1", t1[1], 1'b1);
    bus.in_valid = 1'b0;
    step();
    expect_out("t1_i2", t1[2], 1'b1);
    check("t1_issue_cnt", 32'(issue_cnt), 32'd3);
    check("t1_stall_cnt", 32'(stall_cnt), 32'd0);
    step();
    expect_out("t1_after", 32'd0, 1'b0);
    check("t1_drain1", 32'(state), 32'(STALL));
    step();
    check("t1_drain2", 32'(state), 32'(STALL));
    step();
    check("t1_idle", 32'(state), 32'(IDLE));

    // 2: RAW on rs1 directly behind the producer -> two bubbles
    a = mk(5'd1, 5'd4, 5'd5, 1'b0, 13'h201);
    b = mk(5'd9, 5'd1, 5'd6, 1'b0, 13'h202);
    bus.in_valid = 1'b1;
    bus.in_instr = a;
    step();
    bus.in_instr = b;
    step();
    expect_out("t2_a", a, 1'b1);
    bus.in_valid = 1'b0;
    step();
    expect_out("t2_bub1", 32'd0, 1'b0);
    check("t2_state_stall", 32'(state), 32'(STALL));
    step();
    expect_out("t2_bub2", 32'd0, 1'b0);
    step();
    expect_out("t2_b", b, 1'b1);
    check("t2_stall_cnt", 32'(stall_cnt), 32'd2);
    check("t2_issue_cnt", 32'(issue_cnt), 32'd5);
    drain_to_idle("t2");

    // 3a: immediate form ignores the rs2 field -> no hazard
    a = mk(5'd7, 5'd2, 5'd3, 1'b0, 13'h301);
    b = mk(5'd10, 5'd2, 5'd7, 1'b1, 13'h302);
    bus.in_valid = 1'b1;
    bus.in_instr = a;
    step();
    bus.in_instr = b;
    step();
    expect_out("t3a_a", a, 1'b1);
    bus.in_valid = 1'b0;
    step();
    expect_out("t3a_b", b, 1'b1);
    check("t3a_stall_cnt", 32'(stall_cnt), 32'd2);
    drain_to_idle("t3a");

    // 3b: register form with the same rs2 -> two bubbles
    b = mk(5'd10, 5'd2, 5'd7, 1'b0, 13'h304);
    bus.in_valid = 1'b1;
    bus.in_instr = a;
    step();
    bus.in_instr = b;
    step();
    expect_out("t3b_a", a, 1'b1);
    bus.in_valid = 1'b0;
    step();
    expect_out("t3b_bub1", 32'd0, 1'b0);
    step();
    expect_out("t3b_bub2", 32'd0, 1'b0);
    step();
    expect_out("t3b_b", b, 1'b1);
    check("t3b_stall_cnt", 32'(stall_cnt), 32'd4);
    check("t3b_issue_cnt", 32'(issue_cnt), 32'd9);
    drain_to_idle("t3b");

    // 4: hold fills the FIFO; the fifth push is refused
    for (int i = 0; i < 5; i++)
      h[i] = mk(5'(11 + i), 5'd20, 5'd21, 1'b0, 13'(16'h400 + i));
    bus.hold     = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_instr = h[i];
      step();
    end
    bus.in_valid = 1'b0;
    check("t4_ready_full", 32'(bus.in_ready), 32'd0);
    check("t4_count_full", 32'(fifo_count), 32'd4);
    check("t4_stall_hold", 32'(stall_cnt), 32'd4);
    check("t4_state_hold", 32'(state), 32'(STALL));
    expect_out("t4_hold", 32'd0, 1'b0);
    bus.hold = 1'b0;
    step();
    expect_out("t4_h0", h[0], 1'b1);
    check("t4_ready_back", 32'(bus.in_ready), 32'd1);
    check("t4_count3", 32'(fifo_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      step();
      expect_out($sformatf("t4_h%0d", i), h[i], 1'b1);
    end
    check("t4_issue_cnt", 32'(issue_cnt), 32'd13);
    check("t4_count0", 32'(fifo_count), 32'd0);
    drain_to_idle("t4");

    // 5: independent C stays behind the stalled B
    a = mk(5'd3, 5'd20, 5'd21, 1'b0, 13'h501);
    b = mk(5'd16, 5'd3, 5'd22, 1'b0, 13'h502);
    c = mk(5'd17, 5'd23, 5'd24, 1'b0, 13'h503);
    bus.in_valid = 1'b1;
    bus.in_instr = a;
    step();
    bus.in_instr = b;
    step();
    expect_out("t5_a", a, 1'b1);
    bus.in_instr = c;
    step();
    expect_out("t5_bub1", 32'd0, 1'b0);
    bus.in_valid = 1'b0;
    step();
    expect_out("t5_bub2", 32'd0, 1'b0);
    step();
    expect_out("t5_b", b, 1'b1);
    step();
    expect_out("t5_c", c, 1'b1);
    check("t5_stall_cnt", 32'(stall_cnt), 32'd6);
    check("t5_issue_cnt", 32'(issue_cnt), 32'd16);
    drain_to_idle("t5");

    // 6: reset during a stall with three queued, with a push in the same cycle
    a = mk(5'd5, 5'd20, 5'd21, 1'b0, 13'h601);
    b = mk(5'd18, 5'd5, 5'd22, 1'b0, 13'h602);
    c = mk(5'd19, 5'd23, 5'd24, 1'b0, 13'h603);
    d = mk(5'd20, 5'd25, 5'd26, 1'b0, 13'h604);
    e = mk(5'd21, 5'd27, 5'd28, 1'b0, 13'h605);
    f = mk(5'd22, 5'd5, 5'd18, 1'b0, 13'h606);
    bus.in_valid = 1'b1;
    bus.in_instr = a;
    step();
    bus.in_instr = b;
    step();
    expect_out("t6_a", a, 1'b1);
    bus.in_instr = c;
    step();
    bus.in_instr = d;
    step();
    check("t6_count_pre", 32'(fifo_count), 32'd3);
    check("t6_state_pre", 32'(state), 32'(STALL));
    rst          = 1'b1;
    bus.in_instr = e;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    expect_out("t6_rst", 32'd0, 1'b0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_stall", 32'(stall_cnt), 32'd0);
    check("t6_issue", 32'(issue_cnt), 32'd0);
    check("t6_state", 32'(state), 32'(IDLE));
    bus.in_valid = 1'b1;
    bus.in_instr = f;
    step();
    bus.in_valid = 1'b0;
    step();
    expect_out("t6_f", f, 1'b1);
    check("t6_issue_f", 32'(issue_cnt), 32'd1);
    step();
    expect_out("t6_empty", 32'd0, 1'b0);
    check("t6_stall_f", 32'(stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
